axi4_decerr_slave: RTL and testbench
====================================

Name: axi4_decerr_slave

Overview:
- Default (error) slave directly downstream of the interconnect address decoder.
- Any AW/AR transaction for which the decoder asserts access_error, or selects no slave, is routed here.
- Completes the transaction AXI4-legally with DECERR:
  - Writes: drains the write data, then returns one B response.
  - Reads: returns ARLEN+1 R beats.
- Logs the count and the last address of errored transactions for the system-register block.

Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr and err_addr
- ID_WIDTH, 4, width of AXI ID fields
- DATA_WIDTH, 64, width of wdata/rdata
- CNT_WIDTH, 16, width of the saturating error counter

Ports:
- aclk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- awid  input  ID_WIDTH  write address ID
- awaddr  input  ADDR_WIDTH  write address
- awvalid  input  1  write address valid
- awready  output  1  write address ready
- wdata  input  DATA_WIDTH  write data (ignored)
- wlast  input  1  last write beat
- wvalid  input  1  write data valid
- wready  output  1  write data ready
- bid  output  ID_WIDTH  response ID
- bresp  output  2  write response
- bvalid  output  1  write response valid
- bready  input  1  write response ready
- arid  input  ID_WIDTH  read address ID
- araddr  input  ADDR_WIDTH  read address
- arlen  input  8  read burst length minus 1
- arvalid  input  1  read address valid
- arready  output  1  read address ready
- rid  output  ID_WIDTH  read ID
- rdata  output  DATA_WIDTH  read data
- rresp  output  2  read response
- rlast  output  1  last read beat
- rvalid  output  1  read data valid
- rready  input  1  read data ready
- err_clear  input  1  synchronous clear of error log
- err_count  output  CNT_WIDTH  saturating count of errored transactions
- err_addr  output  ADDR_WIDTH  address of most recent errored transaction
- err_is_write  output  1  1 = most recent error was a write

Behaviour:
- Clock/reset: one clock aclk; reset aresetn is asynchronous, active-low.
- Reset values:
  - All outputs are 0.
  - Both FSMs enter IDLE.
  - awready and arready are registered; each rises in the first cycle after aresetn deasserts.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: awready=1, wready=0. On awvalid&awready, capture awid, drop awready, go to W_DATA.
  - W_DATA: wready=1. Discard every beat. On wvalid&wready&wlast, go to W_RESP with bvalid=1, bid=captured ID, bresp=2'b11.
  - W_RESP: hold bvalid and bid stable until bready. On the handshake, bvalid=0, awready=1, return to W_IDLE.
  - Minimum write turnaround: AW, 1+ W beats, B, then the next AW is accepted the cycle after B completes.
  - wvalid while in W_IDLE or W_RESP is ignored; wready stays 0 in those states.
- Read FSM (R_IDLE, R_DATA):
  - R_IDLE: arready=1. On arvalid&arready, capture arid and arlen, load beat counter=0, arready=0, go to R_DATA.
  - R_DATA: rvalid=1 starting the cycle after AR acceptance. rid=captured ID, rdata=0, rresp=2'b11, rlast=(counter==captured arlen).
  - On rvalid&rready: counter+1. On the last beat, rvalid=0, arready=1, return to R_IDLE.
  - With rready low, rvalid, rlast and rid hold stable.
  - arlen=0 gives a single beat with rlast=1. arlen=255 gives 256 beats; the counter is 8 bits and must not wrap before rlast.
- The read and write FSMs are fully independent; each allows one outstanding transaction.
- Error log:
  - Each AW or AR handshake increments err_count by 1; both in the same cycle increment it by 2.
  - err_count saturates at all-ones and never wraps.
  - err_addr/err_is_write update on each handshake. If AW and AR handshake in the same cycle, the write wins (err_addr=awaddr, err_is_write=1).
  - err_clear zeroes err_count, err_addr and err_is_write. If a handshake occurs in the same cycle, clear applies first, then the increment (count = 1 or 2, address = the new one).
- Reset mid-burst: asynchronous return to reset values. No partial B or R is emitted afterwards, and the pending ID is discarded.

Test Plan:
- Write burst: AW id=0x5 addr=0x3000_0000, 4 W beats with wlast on the 4th -> wready high for exactly those 4 handshakes; bvalid next cycle with bid=0x5, bresp=2'b11; err_count=1, err_addr=0x3000_0000, err_is_write=1.
- Read burst: AR id=0xA arlen=7, rready toggling 1/0 -> exactly 8 R beats with rid=0xA, rresp=2'b11, rdata=0; rlast only on the 8th; signals stable while rready=0.
- Simultaneous AW (addr 0x100) and AR (addr 0x200) in the same cycle -> both accepted; err_count +2; err_addr=0x100, err_is_write=1; B and R complete independently.
- Backpressure: bready held low 10 cycles -> bvalid and bid stable, awready=0; the next AW is accepted only after the B handshake.
- Saturation and clear with CNT_WIDTH=3:
  - 9 errored reads -> err_count=7.
  - err_clear asserted alongside an AR handshake -> err_count=1.
- Reset mid-burst: aresetn low during beat 3 of an arlen=15 read -> all outputs 0 immediately; after release arready=1 one cycle later, no stale R beats; a new arlen=0 read returns a single rlast beat.

Source files
------------

// File: rtl/axi4_decerr_slave.sv
// Default slave behind the address decoder: completes every routed AXI4 burst
// with DECERR and keeps a small error log for the system-register block.
module axi4_decerr_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic                  err_clear,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  err_is_write
);

    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t            w_state_reg;
    logic [ID_WIDTH-1:0] w_id_reg;
    r_state_t            r_state_reg;
    logic [7:0]          r_len_reg;
    logic [7:0]          r_cnt_reg;
    logic [7:0]          r_cnt_next;

    logic                aw_hs;
    logic                ar_hs;
    logic [1:0]          err_inc;
    logic [CNT_WIDTH-1:0] err_base;
    logic [CNT_WIDTH:0]  err_sum;

    // Write data is discarded by design.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    assign rdata      = '0;
    assign aw_hs      = awvalid & awready;
    assign ar_hs      = arvalid & arready;
    assign r_cnt_next = r_cnt_reg + 8'd1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_reg <= W_IDLE;
            w_id_reg    <= '0;
            awready     <= 1'b0;
            wready      <= 1'b0;
            bvalid      <= 1'b0;
            bid         <= '0;
            bresp       <= 2'b00;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_id_reg    <= awid;
                        awready     <= 1'b0;
                        wready      <= 1'b1;
                        w_state_reg <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wvalid && wlast) begin
                        wready      <= 1'b0;
                        bvalid      <= 1'b1;
                        bid         <= w_id_reg;
                        bresp       <= RESP_DECERR;
                        w_state_reg <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid      <= 1'b0;
                        bresp       <= 2'b00;
                        awready     <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_reg <= R_IDLE;
            r_len_reg   <= '0;
            r_cnt_reg   <= '0;
            arready     <= 1'b0;
            rvalid      <= 1'b0;
            rlast       <= 1'b0;
            rid         <= '0;
            rresp       <= 2'b00;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_hs) begin
                        rid         <= arid;
                        r_len_reg   <= arlen;
                        r_cnt_reg   <= '0;
                        arready     <= 1'b0;
                        rvalid      <= 1'b1;
                        rresp       <= RESP_DECERR;
                        rlast       <= (arlen == 8'd0);
                        r_state_reg <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid      <= 1'b0;
                            rlast       <= 1'b0;
                            rresp       <= 2'b00;
                            arready     <= 1'b1;
                            r_state_reg <= R_IDLE;
                        end else begin
                            r_cnt_reg <= r_cnt_next;
                            rlast     <= (r_cnt_next == r_len_reg);
                        end
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // Clear takes effect before this cycle's increment.
    assign err_inc  = {1'b0, aw_hs} + {1'b0, ar_hs};
    assign err_base = err_clear ? '0 : err_count;
    assign err_sum  = {1'b0, err_base} + {{(CNT_WIDTH-1){1'b0}}, err_inc};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_count    <= '0;
            err_addr     <= '0;
            err_is_write <= 1'b0;
        end else begin
            err_count <= err_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : err_sum[CNT_WIDTH-1:0];
            if (aw_hs) begin
                err_addr     <= awaddr;
                err_is_write <= 1'b1;
            end else if (ar_hs) begin
                err_addr     <= araddr;
                err_is_write <= 1'b0;
            end else if (err_clear) begin
                err_addr     <= '0;
                err_is_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_decerr_slave.sv
// Bench for axi4_decerr_slave: directed scenarios followed by random traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_axi4_decerr_slave;

    localparam int AW = 32;
    localparam int IW = 4;
    localparam int DW = 64;
    localparam int CW = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [IW-1:0] awid = '0;
    logic [AW-1:0] awaddr = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [IW-1:0] arid = '0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;
    logic          err_clear = 1'b0;
    logic [CW-1:0] err_count;
    logic [AW-1:0] err_addr;
    logic          err_is_write;

    int n_checks = 0;
    int n_fail = 0;

    axi4_decerr_slave #(
        .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .err_clear(err_clear), .err_count(err_count), .err_addr(err_addr), .err_is_write(err_is_write)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one open write, one read with a count of beats left.
    logic          m_aw_rdy = 1'b0;
    logic          m_w_open = 1'b0;
    logic          m_b_pend = 1'b0;
    logic [IW-1:0] m_w_id = '0;
    logic [IW-1:0] m_b_id = '0;
    logic          m_ar_rdy = 1'b0;
    int            m_beats_left = 0;
    logic [IW-1:0] m_r_id = '0;
    int            m_cnt = 0;
    logic [AW-1:0] m_addr = '0;
    logic          m_isw = 1'b0;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_aw_rdy = 1'b0; m_w_open = 1'b0; m_b_pend = 1'b0;
            m_w_id = '0; m_b_id = '0;
            m_ar_rdy = 1'b0; m_beats_left = 0; m_r_id = '0;
            m_cnt = 0; m_addr = '0; m_isw = 1'b0;
        end else begin
            automatic bit aw_hs = awvalid && m_aw_rdy;
            automatic bit w_end = wvalid && wlast && m_w_open;
            automatic bit b_hs  = m_b_pend && bready;
            automatic bit ar_hs = arvalid && m_ar_rdy;
            automatic bit r_hs  = (m_beats_left > 0) && rready;
            automatic int base  = err_clear ? 0 : m_cnt;

            if (aw_hs) begin
                m_aw_rdy = 1'b0; m_w_open = 1'b1; m_w_id = awid;
                $display("AW  id=%0h addr=%08h t=%0t", awid, awaddr, $time);
            end else if (w_end) begin
                m_w_open = 1'b0; m_b_pend = 1'b1; m_b_id = m_w_id;
            end else if (b_hs) begin
                m_b_pend = 1'b0; m_aw_rdy = 1'b1;
                $display("B   id=%0h t=%0t", m_b_id, $time);
            end else if (!m_w_open && !m_b_pend) begin
                m_aw_rdy = 1'b1;
            end

            if (ar_hs) begin
                m_ar_rdy = 1'b0; m_beats_left = int'(arlen) + 1; m_r_id = arid;
                $display("AR  id=%0h addr=%08h len=%0d t=%0t", arid, araddr, arlen, $time);
            end else if (r_hs) begin
                m_beats_left--;
                if (m_beats_left == 0) m_ar_rdy = 1'b1;
            end else if (m_beats_left == 0) begin
                m_ar_rdy = 1'b1;
            end

            m_cnt = base + int'(aw_hs) + int'(ar_hs);
            if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
            if (aw_hs) begin
                m_addr = awaddr; m_isw = 1'b1;
            end else if (ar_hs) begin
                m_addr = araddr; m_isw = 1'b0;
            end else if (err_clear) begin
                m_addr = '0; m_isw = 1'b0;
            end
        end
    end

    always @(negedge aclk) begin
        chk("awready", awready, m_aw_rdy);
        chk("wready", wready, m_w_open);
        chk("bvalid", bvalid, m_b_pend);
        chk("bid", bid, m_b_id);
        chk("bresp", bresp, m_b_pend ? 2'b11 : 2'b00);
        chk("arready", arready, m_ar_rdy);
        chk("rvalid", rvalid, m_beats_left > 0);
        chk("rlast", rlast, m_beats_left == 1);
        chk("rid", rid, m_r_id);
        chk("rresp", rresp, (m_beats_left > 0) ? 2'b11 : 2'b00);
        chk("rdata", rdata, 64'd0);
        chk("err_count", err_count, m_cnt[CW-1:0]);
        chk("err_addr", err_addr, m_addr);
        chk("err_is_write", err_is_write, m_isw);
    end

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic do_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, output int waited);
        bit got = 0;
        awid = id; awaddr = addr; awvalid = 1'b1;
        waited = 0;
        for (int i = 0; i < 100; i++) begin
            got = awready;
            tick();
            if (got) break;
            waited++;
        end
        awvalid = 1'b0;
        chk("aw_accept", got, 1);
    endtask

    task automatic do_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
        bit got = 0;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            got = arready;
            tick();
            if (got) break;
        end
        arvalid = 1'b0;
        chk("ar_accept", got, 1);
    endtask

    task automatic do_w(input int n);
        int beats = 0;
        wvalid = 1'b1;
        for (int i = 0; i < 200 && beats < n; i++) begin
            automatic bit hs;
            wlast = (beats == n - 1);
            wdata = {$urandom, $urandom};
            hs = wready;
            tick();
            if (hs) beats++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("w_beats", beats, n);
    endtask

    task automatic do_b(input logic [IW-1:0] id, input int hold);
        bit seen = 0;
        bit got = 0;
        bready = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (bvalid) seen = 1; else tick();
        end
        chk("b_seen", seen, 1);
        for (int i = 0; i < hold; i++) begin
            chk("b_hold_valid", bvalid, 1);
            chk("b_hold_id", bid, id);
            chk("b_hold_awready", awready, 0);
            tick();
        end
        chk("b_id", bid, id);
        chk("b_resp", bresp, 2'b11);
        bready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            got = bvalid;
            tick();
            if (got) break;
        end
        bready = 1'b0;
        chk("b_done", got, 1);
    endtask

    task automatic do_r(input int n, input logic [IW-1:0] id, input bit toggle);
        int beats = 0;
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            automatic bit hs;
            rready = toggle ? bit'(i % 2) : 1'b1;
            hs = rvalid && rready;
            if (hs) begin
                chk("r_id", rid, id);
                chk("r_last", rlast, beats == n - 1);
                done = rlast;
                beats++;
            end
            tick();
        end
        rready = 1'b0;
        chk("r_beats", beats, n);
        $display("R   id=%0h beats=%0d t=%0t", id, beats, $time);
    endtask

    initial begin
        int waited;
        repeat (3) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        chk("awready_reset", awready, 0);
        chk("arready_reset", arready, 0);
        chk("err_count_reset", err_count, 0);
        tick();
        chk("awready_rise", awready, 1);
        chk("arready_rise", arready, 1);

        // Write burst of four beats.
        do_aw(4'h5, 32'h3000_0000, waited);
        do_w(4);
        do_b(4'h5, 0);
        chk("wr_err_count", err_count, 1);
        chk("wr_err_addr", err_addr, 32'h3000_0000);
        chk("wr_err_is_write", err_is_write, 1);

        // Read burst of eight beats with rready toggling.
        do_ar(4'hA, 32'h4000_0040, 8'd7);
        do_r(8, 4'hA, 1);
        chk("rd_err_count", err_count, 2);
        chk("rd_err_is_write", err_is_write, 0);

        // AW and AR in the same cycle.
        awid = 4'h1; awaddr = 32'h100; awvalid = 1'b1;
        arid = 4'h2; araddr = 32'h200; arlen = 8'd2; arvalid = 1'b1;
        chk("sim_awready", awready, 1);
        chk("sim_arready", arready, 1);
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        chk("sim_err_count", err_count, 4);
        chk("sim_err_addr", err_addr, 32'h100);
        chk("sim_err_is_write", err_is_write, 1);
        do_r(3, 4'h2, 0);
        do_w(1);
        do_b(4'h1, 0);

        // B backpressure with a second AW waiting.
        do_aw(4'h3, 32'h400, waited);
        do_w(1);
        awid = 4'h6; awaddr = 32'h500; awvalid = 1'b1;
        do_b(4'h3, 10);
        chk("bp_count_before", err_count, 5);
        chk("bp_awready_after_b", awready, 1);
        do_aw(4'h6, 32'h500, waited);
        chk("bp_aw_wait", waited, 0);
        chk("bp_count_after", err_count, 6);
        do_w(2);
        do_b(4'h6, 0);

        // Saturation then clear coinciding with an AR.
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("clr_count", err_count, 0);
        chk("clr_addr", err_addr, 0);
        for (int i = 0; i < 9; i++) begin
            do_ar(4'h4, 32'h800 + 32'(i), 8'd0);
            do_r(1, 4'h4, 0);
        end
        chk("sat_count", err_count, 7);
        err_clear = 1'b1;
        do_ar(4'h9, 32'h900, 8'd0);
        err_clear = 1'b0;
        chk("clr_hs_count", err_count, 1);
        chk("clr_hs_addr", err_addr, 32'h900);
        do_r(1, 4'h9, 0);

        // Asynchronous reset during beat 3 of a 16-beat read.
        do_ar(4'hC, 32'hA00, 8'd15);
        rready = 1'b1;
        tick();
        tick();
        #1;
        aresetn = 1'b0;
        #1;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rid", rid, 0);
        chk("rst_arready", arready, 0);
        chk("rst_err_count", err_count, 0);
        rready = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        chk("rel_arready", arready, 0);
        tick();
        chk("rel_arready_rise", arready, 1);
        chk("rel_rvalid", rvalid, 0);
        do_ar(4'h7, 32'hB00, 8'd0);
        do_r(1, 4'h7, 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            awvalid = ($urandom % 3) == 0;
            awid = IW'($urandom);
            awaddr = $urandom;
            wvalid = ($urandom % 2) == 0;
            wlast = ($urandom % 3) == 0;
            wdata = {$urandom, $urandom};
            bready = ($urandom % 5) < 3;
            arvalid = ($urandom % 3) == 0;
            arid = IW'($urandom);
            araddr = $urandom;
            arlen = (($urandom % 60) == 0) ? 8'd255 : 8'($urandom % 8);
            rready = ($urandom % 5) < 3;
            err_clear = ($urandom % 40) == 0;
            tick();
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; err_clear = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
